// File: rtl/flop_r.sv
// flop_r: WIDTH-bit D flip-flop with an asynchronous, active-low reset that loads RESET_VALUE.
// q comes straight from the state register, so d and clk never reach it combinationally.
`timescale 1ns/100ps
module flop_r #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Capture d on every rising edge; a falling reset overrides capture at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: tb/tb_flop_r.sv
// Directed self-checking bench for flop_r: a default 32-bit instance plus
// an 8-bit instance with a non-zero reset value.
`timescale 1ns/100ps
module tb_flop_r;

  logic        clk;
  logic        clk_run;
  logic        reset;
  logic [31:0] d;
  logic [31:0] q;
  logic        reset8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int n_cmp;
  int n_bad;

  flop_r dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  flop_r #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .d     (d8),
    .q     (q8)
  );

  // 10 ns clock that can be frozen at its current level.
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    clk_run = 1'b1;
    reset   = 1'b1;
    reset8  = 1'b1;
    d       = 32'h0000_0004;
    d8      = 8'h00;

    // Power-up with reset asserted while the clock runs.
    #0.5;
    reset  = 1'b0;
    reset8 = 1'b0;
    #0.5;
    chk("por_t1", q, 32'h0000_0000);
    chk("p8_reset", {24'h0, q8}, 32'h0000_003C);
    @(posedge clk); #1;
    chk("por_e1", q, 32'h0000_0000);
    @(posedge clk); #1;
    chk("por_e2", q, 32'h0000_0000);
    reset = 1'b1;
    d     = 32'h0000_0004;
    #0.1;
    chk("rel_nochg", q, 32'h0000_0000);
    @(negedge clk); #1;
    chk("rel_negedge", q, 32'h0000_0000);
    @(posedge clk); #1;
    chk("first_cap", q, 32'h0000_0004);

    // Streaming: each value appears exactly one edge after it is applied.
    d = 32'hDEAD_BEEF;
    #1;
    chk("str_lat0", q, 32'h0000_0004);
    @(posedge clk); #1;
    chk("str_0", q, 32'hDEAD_BEEF);
    d = 32'h1234_5678;
    #1;
    chk("str_lat1", q, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("str_1", q, 32'h1234_5678);
    d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("str_2", q, 32'hFFFF_FFFF);

    // Hold: d wiggles between edges, including right on the falling edge.
    d = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    chk("hold_load", q, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      #1;
      chk("hold_mid", q, 32'hA5A5_A5A5);
      @(negedge clk);
      d = $urandom;
      #1;
      chk("hold_neg", q, 32'hA5A5_A5A5);
      d = $urandom;
      if (i < 2) begin
        @(posedge clk); #1;
        d = 32'hA5A5_A5A5;
        @(posedge clk); #1;
      end
    end
    d = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    chk("hold_next", q, 32'h0F0F_0F0F);

    // Async reset with clk frozen high.
    d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("ar_load", q, 32'hFFFF_FFFF);
    clk_run = 1'b0;
    #7;
    reset = 1'b0;
    #0.1;
    chk("ar_stopped_hi", q, 32'h0000_0000);
    d = 32'h0000_0001;
    clk_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ar_held", q, 32'h0000_0000);
    end
    // Release with the clock frozen low, then capture on the first edge.
    @(negedge clk); #1;
    clk_run = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rel_stopped", q, 32'h0000_0000);
    clk_run = 1'b1;
    @(posedge clk); #1;
    chk("rel_cap", q, 32'h0000_0001);

    // Reset falls in the same time step as a capturing edge.
    d = 32'h5555_5555;
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk("collide", q, 32'h0000_0000);
    @(posedge clk); #1;
    chk("collide_hold", q, 32'h0000_0000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("collide_rel", q, 32'h5555_5555);

    // Narrow instance with a non-zero reset value.
    chk("p8_still", {24'h0, q8}, 32'h0000_003C);
    reset8 = 1'b1;
    d8     = 8'h81;
    #1;
    chk("p8_rel", {24'h0, q8}, 32'h0000_003C);
    @(posedge clk); #1;
    chk("p8_cap", {24'h0, q8}, 32'h0000_0081);
    reset8 = 1'b0;
    #0.1;
    chk("p8_rerst", {24'h0, q8}, 32'h0000_003C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flop_r.md
FLOP_R -- requirements
Module: flop_r

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data path width in bits and SHALL be at least 1.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits), SHALL be the value loaded into q on reset.
REQ-003 clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 reset, input, 1 bit, SHALL be the asynchronous, active-low reset (0 = asserted, 1 = normal operation).
REQ-005 d, input, WIDTH bits, SHALL be the data to be registered.
REQ-006 q, output, WIDTH bits, SHALL be the registered data, driven directly from a flip-flop with no combinational path from d or clk.
REQ-007 The block SHALL have exactly one clock, one reset and no other ports.

Function
REQ-008 While reset = 1, on each rising clk edge q SHALL take the value d held immediately before that edge.
REQ-009 Latency d to q SHALL be exactly one clk cycle: a d value applied between edges N-1 and N SHALL appear on q after edge N.
REQ-010 Between rising clk edges, q SHALL hold its value regardless of changes on d.
REQ-011 Falling clk edges SHALL have no effect on q.
REQ-012 All WIDTH bits SHALL be captured together; there SHALL be no partial, sign or width conversion.
REQ-013 q SHALL be defined only by the last captured d or by RESET_VALUE; it SHALL never show X after the first reset.

Reset
REQ-014 When reset falls to 0, q SHALL take RESET_VALUE immediately, without waiting for a clk edge.
REQ-015 While reset = 0, q SHALL stay at RESET_VALUE, and clk edges and d changes SHALL have no effect.
REQ-016 Reset asserted mid-operation, including in the same time step as a rising clk edge, SHALL take priority over capture; q SHALL be RESET_VALUE.
REQ-017 After reset rises to 1, the first rising clk edge SHALL capture d normally; the release itself SHALL not change q.
REQ-018 Reset release SHALL not require clk to be running; reset assertion SHALL work with clk stopped at either level.

Verification
REQ-019 Power-up: reset = 0 for 15 ns with clk at a 10 ns period and d = 0x0000_0004 -> q = 0x0000_0000 throughout; release reset, d = 0x0000_0004 set 1 ns after a rising edge -> q = 0x0000_0004 after the next rising edge, and q remains 0 until that edge.
REQ-020 Streaming: d = 0xDEAD_BEEF, 0x1234_5678, 0xFFFF_FFFF on successive cycles -> q shows each value exactly one cycle later, in order.
REQ-021 Hold: with q = 0xA5A5_A5A5, toggle d randomly between rising edges (including on the falling edge) -> q unchanged until the next rising edge.
REQ-022 Async reset: with q = 0xFFFF_FFFF and clk stopped high, drive reset = 0 -> q = 0x0000_0000 within the same time step; keep reset = 0 across three edges with d = 0x1 -> q stays 0.
REQ-023 Reset/edge collision: reset falls to 0 in the same time step as a rising edge with d = 0x5555_5555 -> q = 0x0000_0000.
REQ-024 Parameterisation: WIDTH = 8, RESET_VALUE = 0x3C, reset = 0 -> q = 0x3C; release reset, d = 0x81 -> q = 0x81 after one rising edge.
